// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
//
// Time-multiplexed driver for an N-digit seven-segment display. A shadow copy
// of the packed hex word, decimal points and per-digit blank mask is captured
// on load. The digits are then scanned one slot at a time. Each slot lasts
// CLK_DIV cycles, and its first cycle is dark so no segment pattern bleeds
// into the neighbouring digit (ghosting).
//
// Parameters:
//   NUM_DIGITS     number of digits scanned (1..8)
//   CLK_DIV        clock cycles per digit slot (>= 2)
//   SEG_ACTIVE_LOW 1 = seg/dp driven low to light
//   AN_ACTIVE_LOW  1 = an driven low to select a digit
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   A digit above digit 0 is dark when its nibble and every higher nibble are
//   zero. Its decimal point still follows dp_in. When the macro is undefined,
//   zero nibbles show "0" and no suppression logic is built.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   load       in   capture strobe for data_in / dp_in / blank_in
//   data_in    in   4*NUM_DIGITS packed nibbles, nibble k -> digit k (0 = right)
//   dp_in      in   decimal point per digit, 1 = lit
//   blank_in   in   1 = digit forced dark (still selected on an)
//   seg        out  segments {g,f,e,d,c,b,a}, registered
//   dp         out  decimal point segment, registered
//   an         out  one-hot digit enable, registered
//   frame_tick out  one-cycle pulse as the digit index wraps to 0
// -----------------------------------------------------------------------------
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_tick
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Inactive output levels after polarity is applied.
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Hex nibble to active-high segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    case (nib)
      4'h0:    decode_hex = 7'h3F;
      4'h1:    decode_hex = 7'h06;
      4'h2:    decode_hex = 7'h5B;
      4'h3:    decode_hex = 7'h4F;
      4'h4:    decode_hex = 7'h66;
      4'h5:    decode_hex = 7'h6D;
      4'h6:    decode_hex = 7'h7D;
      4'h7:    decode_hex = 7'h07;
      4'h8:    decode_hex = 7'h7F;
      4'h9:    decode_hex = 7'h6F;
      4'hA:    decode_hex = 7'h77;
      4'hB:    decode_hex = 7'h7C;
      4'hC:    decode_hex = 7'h39;
      4'hD:    decode_hex = 7'h5E;
      4'hE:    decode_hex = 7'h79;
      default: decode_hex = 7'h71;
    endcase
  endfunction

  state_t                  r_state, w_state_next;
  logic [DIV_W-1:0]        r_div, w_div_next;
  logic [IDX_W-1:0]        r_idx, w_idx_next;
  logic [4*NUM_DIGITS-1:0] r_data;
  logic [NUM_DIGITS-1:0]   r_dp_sh, r_blank;

  logic [6:0]              r_seg, w_seg_next;
  logic                    r_dp, w_dp_next;
  logic [NUM_DIGITS-1:0]   r_an, w_an_next;
  logic                    r_tick, w_tick_next;

  logic                    w_wrap, w_idx_last, w_dark;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [6:0]              w_seg_on;

`ifdef LEADING_ZERO_BLANK_EN
  // w_lz[k] = 1 when nibble k and every nibble above it are zero (k > 0).
  logic [NUM_DIGITS-1:0]   w_lz;

  always_comb begin
    logic v_zero_above;
    v_zero_above = 1'b1;
    w_lz         = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      v_zero_above = v_zero_above && (r_data[4*k +: 4] == 4'h0);
      w_lz[k]      = v_zero_above;
    end
  end

  assign w_dark = r_blank[r_idx] | w_lz[r_idx];
`else
  assign w_dark = r_blank[r_idx];
`endif

  assign w_wrap     = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_nib      = r_data[4*r_idx +: 4];

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_div_next   = w_wrap ? '0 : r_div + DIV_W'(1);
    w_idx_next   = r_idx;
    w_state_next = r_state;
    w_onehot     = '0;
    w_seg_on     = 7'h00;
    w_seg_next   = SEG_OFF;
    w_dp_next    = DP_OFF;
    w_an_next    = AN_OFF;
    w_tick_next  = w_wrap & w_idx_last;

    if (w_wrap) begin
      w_idx_next = w_idx_last ? '0 : r_idx + IDX_W'(1);
    end

    case (r_state)
      ST_BLANK: w_state_next = ST_DRIVE;
      ST_DRIVE: if (w_wrap) w_state_next = ST_BLANK;
      default:  w_state_next = ST_BLANK;
    endcase

    // Output values for the current (divider, index); they land one cycle later.
    if (r_state == ST_DRIVE) begin
      w_onehot[r_idx] = 1'b1;
      w_seg_on        = w_dark ? 7'h00 : decode_hex(w_nib);
      w_an_next       = w_onehot ^ AN_OFF;
      w_seg_next      = w_seg_on ^ SEG_OFF;
      w_dp_next       = (r_dp_sh[r_idx] & ~r_blank[r_idx]) ^ DP_OFF;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BLANK;
      r_div      <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_dp_sh    <= '0;
      r_blank    <= '0;
      r_seg      <= SEG_OFF;
      r_dp       <= DP_OFF;
      r_an       <= AN_OFF;
      r_tick     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_div      <= w_div_next;
      r_idx      <= w_idx_next;
      r_seg      <= w_seg_next;
      r_dp       <= w_dp_next;
      r_an       <= w_an_next;
      r_tick     <= w_tick_next;
      if (load) begin
        r_data   <= data_in;
        r_dp_sh  <= dp_in;
        r_blank  <= blank_in;
      end
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
module tb_sevenseg_scan_driver;

  localparam int N    = 4;
  localparam int DIV  = 4;

  typedef struct packed {
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] an;
    logic         tick;
  } exp_t;

  localparam logic [6:0] DEC [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           load = 1'b0;
  logic [4*N-1:0] data_in = '0;
  logic [N-1:0]   dp_in = '0;
  logic [N-1:0]   blank_in = '0;
  logic [6:0]     seg;
  logic           dp;
  logic [N-1:0]   an;
  logic           frame_tick;

  int total = 0;
  int bad   = 0;

  sevenseg_scan_driver #(
    .NUM_DIGITS(N), .CLK_DIV(DIV), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
    .dp_in(dp_in), .blank_in(blank_in), .seg(seg), .dp(dp), .an(an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: scan counters, shadow registers and scoreboard queue.
  int           m_div = 0;
  int           m_idx = 0;
  logic [4*N-1:0] m_data = '0;
  logic [N-1:0] m_dp = '0;
  logic [N-1:0] m_blank = '0;
  exp_t         q[$];

  function automatic exp_t model_out(input int d, input int i);
    exp_t e;
    logic [3:0] nib;
    logic dark;
    e.seg  = 7'h00;
    e.dp   = 1'b0;
    e.an   = 4'b1111;
    e.tick = (d == DIV - 1) && (i == N - 1);
    if (d != 0) begin
      nib  = m_data[4*i +: 4];
      dark = m_blank[i];
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && (m_data >> (4 * i)) == '0) dark = 1'b1;
`endif
      e.an  = ~(4'b0001 << i);
      e.seg = dark ? 7'h00 : DEC[nib];
      e.dp  = m_dp[i] & ~m_blank[i];
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_div   = 0;
      m_idx   = 0;
      m_data  = '0;
      m_dp    = '0;
      m_blank = '0;
      q.delete();
    end else begin
      q.push_back(model_out(m_div, m_idx));
      if (m_div == DIV - 1) begin
        m_div = 0;
        m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
      end else begin
        m_div = m_div + 1;
      end
      if (load) begin
        m_data  = data_in;
        m_dp    = dp_in;
        m_blank = blank_in;
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({seg, dp, an, frame_tick} !== {7'h00, 1'b0, 4'b1111, 1'b0}) begin
        bad++;
        $display("FAIL reset[%0d]: got seg=%h dp=%b an=%b tick=%b want seg=00 dp=0 an=1111 tick=0",
                 i, seg, dp, an, frame_tick);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    exp_t e;
    int   last_tick = -1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL scan[%0d]: no expected entry queued", i);
      end else begin
        e = q.pop_front();
        if ({seg, dp, an, frame_tick} !== e) begin
          bad++;
          $display("FAIL scan[%0d]: got seg=%h dp=%b an=%b tick=%b want seg=%h dp=%b an=%b tick=%b",
                   i, seg, dp, an, frame_tick, e.seg, e.dp, e.an, e.tick);
        end
      end
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          total++;
          if (i - last_tick != N * DIV) begin
            bad++;
            $display("FAIL tick_period: got %0d want %0d", i - last_tick, N * DIV);
          end
        end
        last_tick = i;
      end
      load    = (i == 1);
      data_in = 16'h12AF;
    end
  endtask

  task automatic test_blank_dp();
    exp_t e;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL blank_dp[%0d]: no expected entry queued", i);
      end else begin
        e = q.pop_front();
        if ({seg, dp, an, frame_tick} !== e) begin
          bad++;
          $display("FAIL blank_dp[%0d]: got seg=%h dp=%b an=%b tick=%b want seg=%h dp=%b an=%b tick=%b",
                   i, seg, dp, an, frame_tick, e.seg, e.dp, e.an, e.tick);
        end
      end
      load     = (i == 0);
      blank_in = 4'b0100;
      dp_in    = 4'b0001;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL reset_mid_wait[%0d]: no expected entry queued", i);
      end else begin
        e = q.pop_front();
        if ({seg, dp, an, frame_tick} !== e) begin
          bad++;
          $display("FAIL reset_mid_wait[%0d]: got seg=%h dp=%b an=%b tick=%b want seg=%h dp=%b an=%b tick=%b",
                   i, seg, dp, an, frame_tick, e.seg, e.dp, e.an, e.tick);
        end
      end
      if (m_idx == 2 && m_div == 2) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_mid: digit2 drive not reached, got idx=%0d want 2", m_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({seg, dp, an, frame_tick} !== {7'h00, 1'b0, 4'b1111, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_async: got seg=%h dp=%b an=%b tick=%b want seg=00 dp=0 an=1111 tick=0",
               seg, dp, an, frame_tick);
    end
    @(negedge clk);
    total++;
    if (an !== 4'b1111) begin
      bad++;
      $display("FAIL reset_mid_hold: got an=%b want an=1111", an);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL reset_mid[%0d]: no expected entry queued", i);
      end else begin
        e = q.pop_front();
        if ({seg, dp, an, frame_tick} !== e) begin
          bad++;
          $display("FAIL reset_mid[%0d]: got seg=%h dp=%b an=%b tick=%b want seg=%h dp=%b an=%b tick=%b",
                   i, seg, dp, an, frame_tick, e.seg, e.dp, e.an, e.tick);
        end
      end
      // Digit 0 first drive cycle after restart shows a zero nibble.
      if (i == 1) begin
        total++;
        if (seg !== 7'h3F || an !== 4'b1110) begin
          bad++;
          $display("FAIL reset_mid_digit0: got seg=%h an=%b want seg=3f an=1110", seg, an);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   armed = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL back_to_back[%0d]: no expected entry queued", i);
      end else begin
        e = q.pop_front();
        if ({seg, dp, an, frame_tick} !== e) begin
          bad++;
          $display("FAIL back_to_back[%0d]: got seg=%h dp=%b an=%b tick=%b want seg=%h dp=%b an=%b tick=%b",
                   i, seg, dp, an, frame_tick, e.seg, e.dp, e.an, e.tick);
        end
      end
      // Load lands on the divider wrap edge.
      load = 1'b0;
      if (!armed && i > 4 && m_div == DIV - 1) begin
        load     = 1'b1;
        data_in  = 16'h5678;
        dp_in    = 4'b1010;
        blank_in = 4'b0000;
        armed    = 1;
      end
    end
  endtask

  task automatic test_leading_zero();
    exp_t e;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL leading_zero[%0d]: no expected entry queued", i);
      end else begin
        e = q.pop_front();
        if ({seg, dp, an, frame_tick} !== e) begin
          bad++;
          $display("FAIL leading_zero[%0d]: got seg=%h dp=%b an=%b tick=%b want seg=%h dp=%b an=%b tick=%b",
                   i, seg, dp, an, frame_tick, e.seg, e.dp, e.an, e.tick);
        end
      end
      load     = (i == 0);
      data_in  = 16'h0030;
      dp_in    = 4'b0000;
      blank_in = 4'b0000;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank_dp();
    test_reset_mid();
    test_back_to_back();
    test_leading_zero();
    load = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
